// File: rtl/rr_arbiter.sv
// Registered round-robin / fixed-priority arbiter with optional grant hold and hold timeout.
// One-hot grant appears one cycle after the request is sampled.
module rr_arbiter #(
  parameter int unsigned NUM_REQ    = 8,
  parameter int unsigned HOLD       = 1,
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned FIXED_PRIO = 0,
  localparam int unsigned IdxW      = $clog2(NUM_REQ),
  localparam int unsigned CntW      = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_gnt_valid,
  output logic [IdxW-1:0]    o_gnt_idx,
  output logic               o_req_up
);

  typedef enum logic {StIdle, StGrant} state_e;

  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_HOLD);

  state_e              r_state, w_state_nxt;
  logic [IdxW-1:0]     r_idx, w_idx_nxt;
  logic [IdxW-1:0]     r_ptr, w_ptr_nxt;
  logic [CntW-1:0]     r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;

  logic [IdxW-1:0]     w_ptr_inc;
  logic [IdxW:0]       w_pick_idle, w_pick_full, w_pick_mask;
  logic                w_owner_req, w_others, w_expired;

  // Returns {found, index}; round robin scans start..NUM_REQ-1 then wraps to 0.
  function automatic logic [IdxW:0] f_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [IdxW-1:0]    start);
    logic            found;
    logic [IdxW-1:0] idx;
    int unsigned     c;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (FIXED_PRIO != 0) begin
        if (req[IdxW'(i)]) begin
          found = 1'b1;
          idx   = IdxW'(i);
        end
      end else begin
        c = 32'(start) + i;
        if (c >= NUM_REQ) c = c - NUM_REQ;
        if (!found && req[IdxW'(c)]) begin
          found = 1'b1;
          idx   = IdxW'(c);
        end
      end
    end
    return {found, idx};
  endfunction

  assign o_req_up    = |i_req;
  assign w_ptr_inc   = (r_idx == IdxW'(NUM_REQ - 1)) ? '0 : r_idx + IdxW'(1);
  assign w_pick_idle = f_pick(i_req, r_ptr);
  assign w_pick_full = f_pick(i_req, w_ptr_inc);
  assign w_pick_mask = f_pick(i_req & ~r_gnt, w_ptr_inc);
  assign w_owner_req = |(i_req & r_gnt);
  assign w_others    = |(i_req & ~r_gnt);
  assign w_expired   = (MAX_HOLD != 0) && (r_cnt == MaxCnt);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    if (!i_en) begin
      w_state_nxt = StIdle;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else if (r_state == StIdle) begin
      if (w_pick_idle[IdxW]) begin
        w_state_nxt = StGrant;
        w_idx_nxt   = w_pick_idle[IdxW-1:0];
        w_cnt_nxt   = CntW'(1);
      end else begin
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    end else if ((HOLD == 0) || !w_owner_req) begin
      // Grant ends: single-cycle mode or owner released; re-arbitrate on this edge.
      w_ptr_nxt = w_ptr_inc;
      if (w_pick_full[IdxW]) begin
        w_state_nxt = StGrant;
        w_idx_nxt   = w_pick_full[IdxW-1:0];
        w_cnt_nxt   = CntW'(1);
      end else begin
        w_state_nxt = StIdle;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    end else if (w_expired && w_others) begin
      w_ptr_nxt   = w_ptr_inc;
      w_idx_nxt   = w_pick_mask[IdxW-1:0];
      w_cnt_nxt   = CntW'(1);
    end else if ((MAX_HOLD != 0) && (r_cnt != MaxCnt)) begin
      w_cnt_nxt   = r_cnt + CntW'(1);
    end
  end

  always_comb begin
    w_gnt_nxt = '0;
    if (w_state_nxt == StGrant) w_gnt_nxt[w_idx_nxt] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = (r_state == StGrant);
  assign o_gnt_idx   = r_idx;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed tables/sequences on four configurations, then
// randomized traffic checked against an owner/pointer/counter reference model.
module tb_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // a: RR single-cycle; b: RR hold, timeout 4; c: fixed prio, unlimited hold; d: 5-wide RR hold
  logic       en_a, en_b, en_c, en_d;
  logic [7:0] req_a, req_b, req_c, gnt_a, gnt_b, gnt_c;
  logic [4:0] req_d, gnt_d;
  logic       val_a, val_b, val_c, val_d, up_a, up_b, up_c, up_d;
  logic [2:0] idx_a, idx_b, idx_c, idx_d;

  rr_arbiter #(.NUM_REQ(8), .HOLD(0), .MAX_HOLD(16), .FIXED_PRIO(0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_a), .i_req(req_a), .o_gnt(gnt_a),
    .o_gnt_valid(val_a), .o_gnt_idx(idx_a), .o_req_up(up_a));
  rr_arbiter #(.NUM_REQ(8), .HOLD(1), .MAX_HOLD(4), .FIXED_PRIO(0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_b), .i_req(req_b), .o_gnt(gnt_b),
    .o_gnt_valid(val_b), .o_gnt_idx(idx_b), .o_req_up(up_b));
  rr_arbiter #(.NUM_REQ(8), .HOLD(1), .MAX_HOLD(0), .FIXED_PRIO(1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_c), .i_req(req_c), .o_gnt(gnt_c),
    .o_gnt_valid(val_c), .o_gnt_idx(idx_c), .o_req_up(up_c));
  rr_arbiter #(.NUM_REQ(5), .HOLD(1), .MAX_HOLD(16), .FIXED_PRIO(0)) u_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_d), .i_req(req_d), .o_gnt(gnt_d),
    .o_gnt_valid(val_d), .o_gnt_idx(idx_d), .o_req_up(up_d));

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {int owner; int ptr; int cnt;} st_t;
  typedef struct {logic [7:0] req; int owner;} vec_t;

  int cfg_n[4]     = '{8, 8, 8, 5};
  int cfg_hold[4]  = '{0, 1, 1, 1};
  int cfg_maxh[4]  = '{16, 4, 0, 16};
  int cfg_fixed[4] = '{0, 0, 1, 0};

  // Index of the winning requester, or -1 when nobody requests.
  function automatic int pick(int n, int fixed, logic [63:0] req, int start);
    if (fixed != 0) begin
      for (int i = n - 1; i >= 0; i--) if (req[i]) return i;
    end else begin
      for (int i = 0; i < n; i++) if (req[(start + i) % n]) return (start + i) % n;
    end
    return -1;
  endfunction

  function automatic st_t step(st_t s, int u, bit en, logic [63:0] req);
    st_t r = s;
    int  n = cfg_n[u];
    int  k = s.owner;
    logic [63:0] others;
    if (!en) begin
      r.owner = -1;
      r.cnt   = 0;
    end else if (k < 0) begin
      r.owner = pick(n, cfg_fixed[u], req, s.ptr);
      r.cnt   = (r.owner >= 0) ? 1 : 0;
    end else begin
      others = req & ~(64'd1 << k);
      if (cfg_hold[u] == 0 || !req[k]) begin
        r.ptr   = (k + 1) % n;
        r.owner = pick(n, cfg_fixed[u], req, r.ptr);
        r.cnt   = (r.owner >= 0) ? 1 : 0;
      end else if (cfg_maxh[u] != 0 && s.cnt >= cfg_maxh[u] && others != 0) begin
        r.ptr   = (k + 1) % n;
        r.owner = pick(n, cfg_fixed[u], others, r.ptr);
        r.cnt   = 1;
      end else if (cfg_maxh[u] != 0 && s.cnt < cfg_maxh[u]) begin
        r.cnt = s.cnt + 1;
      end
    end
    return r;
  endfunction

  task automatic drive(input int u, input bit en, input logic [63:0] r);
    case (u)
      0: begin en_a = en; req_a = r[7:0]; end
      1: begin en_b = en; req_b = r[7:0]; end
      2: begin en_c = en; req_c = r[7:0]; end
      default: begin en_d = en; req_d = r[4:0]; end
    endcase
  endtask

  task automatic sample(input int u, output logic [63:0] g, output logic v, output int i,
                        output logic up);
    case (u)
      0: begin g = 64'(gnt_a); v = val_a; i = int'(idx_a); up = up_a; end
      1: begin g = 64'(gnt_b); v = val_b; i = int'(idx_b); up = up_b; end
      2: begin g = 64'(gnt_c); v = val_c; i = int'(idx_c); up = up_c; end
      default: begin g = 64'(gnt_d); v = val_d; i = int'(idx_d); up = up_d; end
    endcase
  endtask

  // Compare unit u's grant outputs against an expected owner (-1 = no grant).
  task automatic chk(input string name, input int u, input int owner);
    logic [63:0] g, eg;
    logic        v, up, ev;
    int          i, ei;
    sample(u, g, v, i, up);
    eg = (owner >= 0) ? (64'd1 << owner) : 64'd0;
    ev = (owner >= 0);
    ei = (owner >= 0) ? owner : 0;
    n_cmp++;
    if (g !== eg || v !== ev || i != ei) begin
      n_fail++;
      $display("FAIL %s unit%0d @%0t: got gnt=%h valid=%b idx=%0d, want gnt=%h valid=%b idx=%0d",
               name, u, $time, g, v, i, eg, ev, ei);
    end
  endtask

  task automatic chk_up(input int u, input logic [63:0] req);
    logic [63:0] g;
    logic        v, up;
    int          i;
    sample(u, g, v, i, up);
    n_cmp++;
    if (up !== (req != 0)) begin
      n_fail++;
      $display("FAIL req_up unit%0d @%0t: got %b want %b", u, $time, up, req != 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t        tab[16];
  st_t         ms[4];
  logic [63:0] cur[4];
  logic [63:0] flip;
  bit          en_r;

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 4; u++) drive(u, 1'b1, 64'd0);
    #12;
    for (int u = 0; u < 4; u++) chk("reset", u, -1);
    @(negedge clk) rst_n = 1'b1;

    // Single-cycle round robin: full load rotates without bubbles, then wrap/sole-requester cases.
    for (int i = 0; i < 10; i++) tab[i] = '{8'hFF, i % 8};
    tab[10] = '{8'h00, -1};
    tab[11] = '{8'h81, 7};
    tab[12] = '{8'h01, 0};
    tab[13] = '{8'h01, 0};
    tab[14] = '{8'h06, 1};
    tab[15] = '{8'h06, 2};
    for (int i = 0; i < 16; i++) begin
      drive(0, 1'b1, 64'(tab[i].req));
      tick();
      chk("rr_table", 0, tab[i].owner);
    end
    drive(0, 1'b1, 64'd0);

    // Unlimited hold with fixed priority: owner 3 keeps grant while 5 waits.
    for (int i = 0; i < 5; i++) begin
      drive(2, 1'b1, (i < 2) ? 64'h08 : 64'h28);
      tick();
      chk("hold_owner3", 2, 3);
    end
    drive(2, 1'b1, 64'h20);
    tick();
    chk("release_to5", 2, 5);
    drive(2, 1'b1, 64'h00);
    tick();
    chk("release_idle", 2, -1);
    drive(2, 1'b1, 64'hA0);
    tick();
    chk("fixed_prio", 2, 7);
    drive(2, 1'b1, 64'h00);

    // Timeout rotation every 4 cycles between 2 and 6.
    drive(1, 1'b1, 64'h44);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("timeout_rot", 1, ((i / 4) % 2 == 0) ? 2 : 6);
    end
    drive(1, 1'b1, 64'h04);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hold_alone", 1, 2);
    end
    drive(1, 1'b1, 64'h10);
    tick();
    chk("release_to4", 1, 4);
    drive(1, 1'b0, 64'h10);
    tick();
    chk("en_clear", 1, -1);
    drive(1, 1'b1, 64'h11);
    tick();
    chk("en_regrant", 1, 4);

    // Odd width: pointer wraps from 4 back to 0.
    drive(3, 1'b1, 64'h10);
    tick();
    chk("odd_grant4", 3, 4);
    drive(3, 1'b1, 64'h00);
    tick();
    chk("odd_idle", 3, -1);
    drive(3, 1'b1, 64'h11);
    tick();
    chk("odd_wrap", 3, 0);

    // Asynchronous reset mid-grant; first grant afterwards starts from ptr 0.
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst", 1, -1);
    chk("async_rst", 3, -1);
    tick();
    chk("rst_held", 1, -1);
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_ptr0", 1, 0);

    // Randomized traffic on all units against the reference model.
    rst_n = 1'b0;
    for (int u = 0; u < 4; u++) begin
      ms[u]  = '{-1, 0, 0};
      cur[u] = 64'd0;
      drive(u, 1'b1, 64'd0);
    end
    #2 rst_n = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int u = 0; u < 4; u++) begin
        flip   = {$urandom, $urandom} & {$urandom, $urandom};
        cur[u] = (cur[u] ^ flip) & ((64'd1 << cfg_n[u]) - 64'd1);
        en_r   = ($urandom_range(15) != 0);
        drive(u, en_r, cur[u]);
        ms[u]  = step(ms[u], u, en_r, cur[u]);
      end
      tick();
      for (int u = 0; u < 4; u++) begin
        chk("random", u, ms[u].owner);
        chk_up(u, cur[u]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised, registered round-robin arbiter that replaces the fixed-priority ps2/ps4/ps8 selector tree wherever a shared resource needs fairness or grant ownership. Examples are a shared CDB port or memory bus. It takes NUM_REQ request lines and returns a one-hot grant one cycle later. A grant may be single-cycle or held while the owner keeps requesting, and a hold-timeout counter forces rotation. A fixed-priority mode keeps drop-in compatibility with the old selectors.

## Interface
- NUM_REQ, 8, number of requesters; legal range 2 to 64.
- HOLD, 1, grant mode. 1 holds the grant while the owner keeps its request high. 0 makes every grant last exactly one cycle.
- MAX_HOLD, 16, maximum consecutive grant cycles per owner when HOLD=1. 0 means unlimited.
- FIXED_PRIO, 0, priority mode. 1 uses fixed priority where the highest index wins, matching the legacy selectors. 0 uses round robin.
- clock, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- en, input, 1, arbitration enable; 0 forces the grant to zero on the next edge.
- req, input, NUM_REQ, request lines; bit i is requester i.
- gnt, output, NUM_REQ, registered one-hot grant, or all-zero.
- gnt_valid, output, 1, registered; equals the OR of all gnt bits.
- gnt_idx, output, clog2(NUM_REQ), registered index of the granted bit; 0 when gnt_valid=0.
- req_up, output, 1, combinational OR of all req bits, independent of en. Used for tree cascading.

## Operation
- State:
  - ptr, clog2(NUM_REQ) bits, the round-robin start index.
  - hold_cnt, clog2(MAX_HOLD+1) bits.
  - The gnt register. There are two states: IDLE (gnt=0) and GRANT (gnt[k]=1).
- Winner selection (combinational, from the current req and a mask):
  - Round robin: the first set bit scanning ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1. Wrap is modulo NUM_REQ; NUM_REQ need not be a power of two.
  - FIXED_PRIO=1: the highest-index set bit; ptr is ignored but still updated.
- IDLE: if en=1 and the OR of req is 1, the next state is GRANT to the winner and hold_cnt is set to 1. Otherwise the block stays in IDLE.
- GRANT to k with HOLD=0:
  - The grant lasts one cycle.
  - The next edge re-arbitrates over the full req vector with ptr=k+1.
  - k may win again only if it is the sole requester.
  - Back-to-back grants to different requesters have no idle bubble.
- GRANT to k with HOLD=1:
  - If req[k]=1 and the timeout has not expired: keep gnt[k] and increment hold_cnt, saturating at MAX_HOLD.
  - If req[k]=0: release. ptr becomes k+1 and the block re-arbitrates on the same edge, so the next owner is granted with no idle cycle when another request is pending. With no request pending, the block goes to IDLE.
  - Timeout: when MAX_HOLD≠0, hold_cnt=MAX_HOLD, and any other request is pending, the grant rotates to the winner with bit k masked, and ptr becomes k+1. If no other request is pending, k keeps the grant and hold_cnt stays saturated.
- ptr updates only when a grant ends (release, rotation, or a HOLD=0 grant cycle). It does not update on en=0.
- en=0 on any cycle: next state IDLE, gnt=0, hold_cnt=0, ptr unchanged.
- Invariants:
  - gnt is one-hot or zero.
  - gnt_valid equals the OR of all gnt bits.
  - gnt_idx encodes gnt.
  - gnt[i] rises only if req[i]=1 in the prior cycle.
  - gnt never changes owner while HOLD=1, req[owner]=1, and the timeout has not expired.

## Timing
- Reset (reset=0, asynchronous): gnt=0, gnt_valid=0, gnt_idx=0, ptr=0, hold_cnt=0, state IDLE. These hold while reset is low.
- Latency: request sampled at edge N, grant visible after edge N, so one cycle.
- Release latency: req[k] falls before edge N; gnt[k] falls after edge N, and the next owner's grant rises after the same edge.
- req_up: zero latency, purely combinational.
- Reset asserted mid-grant: outputs clear immediately without waiting for a clock. The first grant after reset follows the IDLE rules with ptr=0.
- Simultaneous release and a new request from the same requester: it is treated as a release, and the requester re-competes from ptr=k+1.

## Test plan
- Reset and fixed priority:
  - Reset low mid-grant clears outputs asynchronously.
  - After release, with FIXED_PRIO=1 and req=8'b1010_0000 held, the next cycle gives gnt=8'b1000_0000 and gnt_idx=7.
- Round robin, HOLD=0: req=8'hFF held for 10 cycles gives grants to 0,1,2,...,7,0,1 on consecutive cycles with no bubbles.
- Hold and release, HOLD=1, MAX_HOLD=0:
  - req[3] for 5 cycles, then req[5] asserted during that time.
  - gnt[3] is held all 5 cycles; gnt[5] rises on the edge after req[3] falls.
- Timeout, MAX_HOLD=4: req[2] and req[6] both held gives the sequence gnt[2]×4, gnt[6]×4, gnt[2]×4.
  - With req[2] alone, gnt[2] stays high indefinitely.
- Enable: en=0 for 1 cycle during gnt[4] clears gnt next cycle with ptr unchanged. With en=1 and req[4] still high, gnt[4] is re-granted.
- Wrap and odd width, NUM_REQ=5:
  - Grant to 4 then release gives ptr=0.
  - With req=5'b10001, requester 0 is granted next.
  - Randomised req for 10k cycles produces no invariant violation.
